// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-macro signals around mem_port_arbiter.
// slave is the arbiter's view; master is the core-plus-memory view.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  // Instruction-fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          if_stall;

  // Load/store data port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_be;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  // Memory macro side
  logic          mem_en;
  logic          mem_we;
  logic [AW-3:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_stall,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_stall,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and
// load/store. Data wins by default; after MAX_STREAK consecutive data grants
// with fetch waiting, fetch is granted once so the core keeps fetching.
// Read responses come back one cycle after the grant, steered by an owner FSM.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IF_RD = 2'd1,
    OWN_D_RD  = 2'd2
  } owner_t;

  owner_t     owner_p1;
  owner_t     owner_nxt;
  logic [3:0] streak_p1;
  logic [3:0] streak_nxt;
  logic       fetch_turn;
  logic       if_gnt;
  logic       d_gnt;

  // Saturating increment: the counter sticks at the limit instead of wrapping.
  function automatic logic [3:0] streak_sat_inc(input logic [3:0] cur);
    if (cur >= STREAK_MAX) return STREAK_MAX;
    return cur + 4'd1;
  endfunction

  // Grant: data first, fetch only alone or once the data streak has hit its limit.
  always_comb begin
    fetch_turn = (streak_p1 == STREAK_MAX);
    d_gnt      = rst & bus.d_req & ~(bus.if_req & fetch_turn);
    if_gnt     = rst & bus.if_req & (~bus.d_req | fetch_turn);
  end

  assign bus.if_gnt   = if_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.if_stall = bus.if_req & ~if_gnt;

  // Memory mux: the granted port drives the macro; idle cycles present all zeros.
  always_comb begin
    bus.mem_en    = if_gnt | d_gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = 4'h0;
    if (d_gnt) begin
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr[AW-1:2];
      bus.mem_wdata = bus.d_wdata;
      bus.mem_be    = bus.d_be;
    end else if (if_gnt) begin
      bus.mem_addr  = bus.if_addr[AW-1:2];
      bus.mem_be    = 4'hF;
    end
  end

  // Streak next value: count data grants that made a waiting fetch wait longer.
  always_comb begin
    streak_nxt = streak_p1;
    if (if_gnt || !bus.if_req) begin
      streak_nxt = 4'd0;
    end else if (d_gnt) begin
      streak_nxt = streak_sat_inc(streak_p1);
    end
  end

  // Streak register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) streak_p1 <= 4'd0;
    else      streak_p1 <= streak_nxt;
  end

  // Owner next state: remember which port's read is coming back next cycle.
  always_comb begin
    owner_nxt = OWN_NONE;
    if (if_gnt)                  owner_nxt = OWN_IF_RD;
    else if (d_gnt && !bus.d_we) owner_nxt = OWN_D_RD;
  end

  // Owner register; reset drops any in-flight read response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) owner_p1 <= OWN_NONE;
    else      owner_p1 <= owner_nxt;
  end

  assign bus.if_rvalid = (owner_p1 == OWN_IF_RD);
  assign bus.d_rvalid  = (owner_p1 == OWN_D_RD);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte-enabled memory.
// Memory word i starts as 32'hA000_0000 + i.
module tb_mem_port_arbiter;
  localparam int AW         = 8;
  localparam int DW         = 32;
  localparam int MAX_STREAK = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [DW-1:0] mem [64];

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(MAX_STREAK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory preload
  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
  end

  // Single-port memory: byte-enabled writes, registered reads.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_be    = 4'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  bit exp_d  [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  bit exp_d6 [5]  = '{1, 1, 1, 1, 0};

  initial begin
    // 1: reset with both requests pending
    rst = 1'b0;
    idle();
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b1;
    bus.d_addr = 8'h04;
    @(negedge clk);
    check("rst_if_gnt",    64'(bus.if_gnt),    64'd0);
    check("rst_d_gnt",     64'(bus.d_gnt),     64'd0);
    check("rst_mem_en",    64'(bus.mem_en),    64'd0);
    check("rst_mem_we",    64'(bus.mem_we),    64'd0);
    check("rst_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    check("rst_d_rvalid",  64'(bus.d_rvalid),  64'd0);
    next_cycle();
    rst       = 1'b1;
    bus.d_we  = 1'b0;
    @(negedge clk);
    check("rel_d_gnt",    64'(bus.d_gnt),    64'd1);
    check("rel_if_gnt",   64'(bus.if_gnt),   64'd0);
    check("rel_if_stall", 64'(bus.if_stall), 64'd1);
    check("rel_mem_addr", 64'(bus.mem_addr), 64'h01);
    next_cycle();
    idle();
    @(negedge clk);
    check("rel_d_rvalid", 64'(bus.d_rvalid), 64'd1);
    check("rel_d_rdata",  64'(bus.d_rdata),  64'hA000_0001);

    // 2: fetch only
    next_cycle();
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h14;
    @(negedge clk);
    check("f_if_gnt",   64'(bus.if_gnt),   64'd1);
    check("f_mem_addr", 64'(bus.mem_addr), 64'h05);
    check("f_mem_en",   64'(bus.mem_en),   64'd1);
    check("f_mem_we",   64'(bus.mem_we),   64'd0);
    check("f_mem_be",   64'(bus.mem_be),   64'hF);
    check("f_if_stall", 64'(bus.if_stall), 64'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check("f_if_rvalid", 64'(bus.if_rvalid), 64'd1);
    check("f_if_rdata",  64'(bus.if_rdata),  64'hA000_0005);
    check("f_d_rvalid",  64'(bus.d_rvalid),  64'd0);

    // 3: contention, both requests held for ten cycles
    next_cycle();
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h10;
    bus.d_req   = 1'b1;
    bus.d_addr  = 8'h08;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("c%0d_d_gnt", k),    64'(bus.d_gnt),    64'(exp_d[k]));
      check($sformatf("c%0d_if_gnt", k),   64'(bus.if_gnt),   64'(!exp_d[k]));
      check($sformatf("c%0d_if_stall", k), 64'(bus.if_stall), 64'(exp_d[k]));
      if (k > 0) begin
        check($sformatf("c%0d_d_rvalid", k),  64'(bus.d_rvalid),  64'(exp_d[k-1]));
        check($sformatf("c%0d_if_rvalid", k), 64'(bus.if_rvalid), 64'(!exp_d[k-1]));
        check($sformatf("c%0d_rdata", k), 64'(bus.d_rdata),
              exp_d[k-1] ? 64'hA000_0002 : 64'hA000_0004);
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    check("c_last_if_rvalid", 64'(bus.if_rvalid), 64'd1);
    check("c_last_if_rdata",  64'(bus.if_rdata),  64'hA000_0004);

    // 4: full store then load of the same word
    next_cycle();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 8'h20;
    bus.d_wdata = 32'hDEADBEEF;
    bus.d_be    = 4'hF;
    @(negedge clk);
    check("st_d_gnt",     64'(bus.d_gnt),     64'd1);
    check("st_mem_we",    64'(bus.mem_we),    64'd1);
    check("st_mem_addr",  64'(bus.mem_addr),  64'h08);
    check("st_mem_wdata", 64'(bus.mem_wdata), 64'hDEADBEEF);
    next_cycle();
    bus.d_we    = 1'b0;
    bus.d_wdata = '0;
    bus.d_be    = 4'h0;
    @(negedge clk);
    check("st_no_rvalid", 64'(bus.d_rvalid), 64'd0);
    check("ld_d_gnt",     64'(bus.d_gnt),    64'd1);
    next_cycle();
    idle();
    @(negedge clk);
    check("ld_d_rvalid", 64'(bus.d_rvalid), 64'd1);
    check("ld_d_rdata",  64'(bus.d_rdata),  64'hDEADBEEF);

    // 5: partial store to word 9, then read back
    next_cycle();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 8'h24;
    bus.d_wdata = 32'h1234_5678;
    bus.d_be    = 4'b0011;
    @(negedge clk);
    check("ps_mem_be", 64'(bus.mem_be), 64'h3);
    check("ps_mem_we", 64'(bus.mem_we), 64'd1);
    check("ps_mem_en", 64'(bus.mem_en), 64'd1);
    next_cycle();
    idle();
    @(negedge clk);
    check("ps_idle_mem_en",    64'(bus.mem_en),    64'd0);
    check("ps_idle_mem_we",    64'(bus.mem_we),    64'd0);
    check("ps_idle_mem_be",    64'(bus.mem_be),    64'h0);
    check("ps_idle_mem_wdata", 64'(bus.mem_wdata), 64'h0);
    check("ps_idle_mem_addr",  64'(bus.mem_addr),  64'h0);
    next_cycle();
    bus.d_req  = 1'b1;
    bus.d_addr = 8'h24;
    next_cycle();
    idle();
    @(negedge clk);
    check("ps_rd_rvalid", 64'(bus.d_rvalid), 64'd1);
    check("ps_rd_rdata",  64'(bus.d_rdata),  64'hA000_5678);

    // Store then fetch of the same word in consecutive cycles
    next_cycle();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 8'h30;
    bus.d_wdata = 32'hCAFE_F00D;
    bus.d_be    = 4'hF;
    next_cycle();
    idle();
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h30;
    @(negedge clk);
    check("ord_if_gnt", 64'(bus.if_gnt), 64'd1);
    next_cycle();
    idle();
    @(negedge clk);
    check("ord_if_rdata", 64'(bus.if_rdata), 64'hCAFE_F00D);

    // 6a: reset the cycle after a fetch grant drops the response
    next_cycle();
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h18;
    @(negedge clk);
    check("rm_if_gnt", 64'(bus.if_gnt), 64'd1);
    next_cycle();
    idle();
    rst = 1'b0;
    @(negedge clk);
    check("rm_if_rvalid_rst", 64'(bus.if_rvalid), 64'd0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rm_if_rvalid_rel", 64'(bus.if_rvalid), 64'd0);
    check("rm_d_rvalid_rel",  64'(bus.d_rvalid),  64'd0);

    // 6b: reset clears a partly built streak
    next_cycle();
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h10;
    bus.d_req   = 1'b1;
    bus.d_addr  = 8'h08;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("sb%0d_d_gnt", k), 64'(bus.d_gnt), 64'd1);
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    check("sb_rst_d_gnt", 64'(bus.d_gnt), 64'd0);
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("sa%0d_d_gnt", k),  64'(bus.d_gnt),  64'(exp_d6[k]));
      check($sformatf("sa%0d_if_gnt", k), 64'(bus.if_gnt), 64'(!exp_d6[k]));
      next_cycle();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
